// File: rtl/gray2rgb_pkg.sv
// Shared constants and helpers for the gray2rgb_stream colouring stage.
// Mode encodings, heatmap breakpoints and the generic channel width scaler.
package gray2rgb_pkg;

    typedef enum logic [1:0] {
        MODE_REPLICATE = 2'd0,
        MODE_THRESH    = 2'd1,
        MODE_HEATMAP   = 2'd2,
        MODE_INVERT    = 2'd3
    } mode_e;

    localparam logic [7:0] HM_BP1 = 8'd64;
    localparam logic [7:0] HM_BP2 = 8'd128;
    localparam logic [7:0] HM_BP3 = 8'd192;

    // Left-justify x, then OR in copies shifted by win so the bit pattern repeats
    // MSB-first; the top wout bits give replication when widening, truncation otherwise.
    function automatic logic [15:0] scale_w(input logic [15:0] x, input int win, input int wout);
        logic [15:0] just;
        logic [15:0] acc;
        just = x << (16 - win);
        acc  = just;
        for (int k = 1; k < 16; k++) begin
            acc = acc | (just >> (k * win));
        end
        return acc >> (16 - wout);
    endfunction

endpackage

// File: rtl/gray2rgb_heatmap.sv
// Combinational 8-bit heatmap palette: blue -> cyan -> yellow -> red ramp.
module gray2rgb_heatmap
    import gray2rgb_pkg::*;
(
    input  logic [7:0] i_g8,
    output logic [7:0] o_red,
    output logic [7:0] o_green,
    output logic [7:0] o_blue
);

    logic [7:0] w_ramp;

    // 4*(g - segment_base) is just the low 6 bits shifted up by two
    assign w_ramp = {i_g8[5:0], 2'b00};

    always_comb begin
        o_red   = 8'h00;
        o_green = 8'h00;
        o_blue  = 8'h00;
        if (i_g8 < HM_BP1) begin
            o_green = w_ramp;
            o_blue  = 8'hFF;
        end else if (i_g8 < HM_BP2) begin
            o_green = 8'hFF;
            o_blue  = 8'hFF - w_ramp;
        end else if (i_g8 < HM_BP3) begin
            o_red   = w_ramp;
            o_green = 8'hFF;
        end else begin
            o_red   = 8'hFF;
            o_green = 8'hFF - w_ramp;
        end
    end

endmodule

// File: rtl/gray2rgb_stream.sv
// Two-stage back-pressured grayscale-to-RGB colouring stage with per-frame mode.
// Define GRAY2RGB_HEATMAP_EN to compile in the HEATMAP mode.
module gray2rgb_stream
    import gray2rgb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] gray_i,
    input  logic              sof_i,
    input  logic              eol_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] thresh_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  red_o,
    output logic [OUT_W-1:0]  green_o,
    output logic [OUT_W-1:0]  blue_o,
    output logic              sof_o,
    output logic              eol_o
);

    logic              w_s1_acc;
    logic              w_s2_acc;
    logic              w_in_fire;
    mode_e             w_mode_in;
    mode_e             w_beat_mode;
    logic [DATA_W-1:0] w_beat_thresh;

    mode_e             r_active_mode;
    logic [DATA_W-1:0] r_active_thresh;

    logic              r_vld_p1;
    logic [DATA_W-1:0] r_gray_p1;
    logic [DATA_W-1:0] r_thresh_p1;
    mode_e             r_mode_p1;
    logic              r_sof_p1;
    logic              r_eol_p1;

    logic [DATA_W-1:0] w_inv_p1;
    logic [OUT_W-1:0]  w_rep;
    logic [OUT_W-1:0]  w_inv;
    logic [OUT_W-1:0]  w_red;
    logic [OUT_W-1:0]  w_green;
    logic [OUT_W-1:0]  w_blue;

    assign w_s2_acc   = !out_valid_o || out_ready_i;
    assign w_s1_acc   = !r_vld_p1 || w_s2_acc;
    assign in_ready_o = w_s1_acc;
    assign w_in_fire  = in_valid_i && w_s1_acc;

`ifdef GRAY2RGB_HEATMAP_EN
    assign w_mode_in = mode_e'(mode_i);
`else
    assign w_mode_in = (mode_i == MODE_HEATMAP) ? MODE_REPLICATE : mode_e'(mode_i);
`endif

    // A sof beat uses the freshly presented settings, others use the latched ones
    assign w_beat_mode   = sof_i ? w_mode_in : r_active_mode;
    assign w_beat_thresh = sof_i ? thresh_i  : r_active_thresh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_mode   <= MODE_REPLICATE;
            r_active_thresh <= '0;
        end else if (w_in_fire && sof_i) begin
            r_active_mode   <= w_mode_in;
            r_active_thresh <= thresh_i;
        end
    end

    // ---- stage 1: capture sample, resolved mode, threshold, sideband ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_acc) begin
            r_vld_p1 <= in_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_gray_p1   <= gray_i;
            r_thresh_p1 <= w_beat_thresh;
            r_mode_p1   <= w_beat_mode;
            r_sof_p1    <= sof_i;
            r_eol_p1    <= eol_i;
        end
    end

    // ---- stage 2: colour computation and output registers ----
    assign w_inv_p1 = ~r_gray_p1;
    assign w_rep    = OUT_W'(scale_w(16'(r_gray_p1), DATA_W, OUT_W));
    assign w_inv    = OUT_W'(scale_w(16'(w_inv_p1), DATA_W, OUT_W));

`ifdef GRAY2RGB_HEATMAP_EN
    logic [7:0]       w_g8;
    logic [7:0]       w_hm_red;
    logic [7:0]       w_hm_green;
    logic [7:0]       w_hm_blue;
    logic [OUT_W-1:0] w_hm_red_s;
    logic [OUT_W-1:0] w_hm_green_s;
    logic [OUT_W-1:0] w_hm_blue_s;

    assign w_g8 = 8'(scale_w(16'(r_gray_p1), DATA_W, 8));

    gray2rgb_heatmap u_heatmap (
        .i_g8    (w_g8),
        .o_red   (w_hm_red),
        .o_green (w_hm_green),
        .o_blue  (w_hm_blue)
    );

    assign w_hm_red_s   = OUT_W'(scale_w({8'h00, w_hm_red},   8, OUT_W));
    assign w_hm_green_s = OUT_W'(scale_w({8'h00, w_hm_green}, 8, OUT_W));
    assign w_hm_blue_s  = OUT_W'(scale_w({8'h00, w_hm_blue},  8, OUT_W));
`endif

    always_comb begin
        w_red   = w_rep;
        w_green = w_rep;
        w_blue  = w_rep;
        case (r_mode_p1)
            MODE_THRESH: begin
                w_red   = (r_gray_p1 >= r_thresh_p1) ? {OUT_W{1'b1}} : '0;
                w_green = w_red;
                w_blue  = w_red;
            end
            MODE_INVERT: begin
                w_red   = w_inv;
                w_green = w_inv;
                w_blue  = w_inv;
            end
`ifdef GRAY2RGB_HEATMAP_EN
            MODE_HEATMAP: begin
                w_red   = w_hm_red_s;
                w_green = w_hm_green_s;
                w_blue  = w_hm_blue_s;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            red_o       <= '0;
            green_o     <= '0;
            blue_o      <= '0;
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
        end else if (w_s2_acc) begin
            out_valid_o <= r_vld_p1;
            if (r_vld_p1) begin
                red_o   <= w_red;
                green_o <= w_green;
                blue_o  <= w_blue;
                sof_o   <= r_sof_p1;
                eol_o   <= r_eol_p1;
            end
        end
    end

endmodule

// File: tb/tb_gray2rgb_stream.sv
// Scoreboard bench for gray2rgb_stream (DATA_W=8, OUT_W=10) with a behavioural colour model.
module tb_gray2rgb_stream;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] gray_i;
    logic              sof_i;
    logic              eol_i;
    logic [1:0]        mode_i;
    logic [DATA_W-1:0] thresh_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [OUT_W-1:0]  red_o;
    logic [OUT_W-1:0]  green_o;
    logic [OUT_W-1:0]  blue_o;
    logic              sof_o;
    logic              eol_o;

    gray2rgb_stream #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .gray_i      (gray_i),
        .sof_i       (sof_i),
        .eol_i       (eol_i),
        .mode_i      (mode_i),
        .thresh_i    (thresh_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .red_o       (red_o),
        .green_o     (green_o),
        .blue_o      (blue_o),
        .sof_o       (sof_o),
        .eol_o       (eol_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int g;
        int b;
        bit sof;
        bit eol;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;
    bit   prev_stall = 0;
    exp_t held;
    int   act_mode = 0;
    int   act_thr = 0;
    bit   last_ov;

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Bit-by-bit MSB-first replication when widening, plain truncation otherwise
    function automatic int scl(input int x, input int win, input int wout);
        int r;
        r = 0;
        if (wout <= win) return x >> (win - wout);
        for (int i = 0; i < wout; i++)
            r = (r << 1) | ((x >> (win - 1 - (i % win))) & 1);
        return r;
    endfunction

    function automatic exp_t model(input int gray, input int mode, input int thr, input bit s, input bit e);
        exp_t x;
        int   v, g8, hr, hg, hb;
        x.sof = s;
        x.eol = e;
        v = scl(gray, DATA_W, OUT_W);
        x.r = v; x.g = v; x.b = v;
        if (mode == 1) begin
            v = (gray >= thr) ? (1 << OUT_W) - 1 : 0;
            x.r = v; x.g = v; x.b = v;
        end else if (mode == 3) begin
            v = scl(((1 << DATA_W) - 1) - gray, DATA_W, OUT_W);
            x.r = v; x.g = v; x.b = v;
        end else if (mode == 2) begin
            g8 = scl(gray, DATA_W, 8);
            if (g8 < 64)       begin hr = 0;                hg = 4 * g8;               hb = 255; end
            else if (g8 < 128) begin hr = 0;                hg = 255;                  hb = 255 - 4 * (g8 - 64); end
            else if (g8 < 192) begin hr = 4 * (g8 - 128);   hg = 255;                  hb = 0; end
            else               begin hr = 255;              hg = 255 - 4 * (g8 - 192); hb = 0; end
            x.r = scl(hr, 8, OUT_W);
            x.g = scl(hg, 8, OUT_W);
            x.b = scl(hb, 8, OUT_W);
        end
        return x;
    endfunction

    task automatic cycle(input bit v, input int g, input bit s, input bit e, input int m,
                         input int t, input bit ordy, output bit acc);
        int exp_rdy;
        int mm;
        @(negedge clk);
        in_valid_i  = v;
        gray_i      = g[DATA_W-1:0];
        sof_i       = s;
        eol_i       = e;
        mode_i      = m[1:0];
        thresh_i    = t[DATA_W-1:0];
        out_ready_i = ordy;
        #1;
        exp_rdy = !(q.size() >= 2 && !ordy);
        chk(int'(in_ready_o) == exp_rdy, "in_ready", int'(in_ready_o), exp_rdy);
        acc = v && in_ready_o;
        if (acc) begin
            if (s) begin
                mm = m & 3;
`ifndef GRAY2RGB_HEATMAP_EN
                if (mm == 2) mm = 0;
`endif
                act_mode = mm;
                act_thr  = t & ((1 << DATA_W) - 1);
            end
            q.push_back(model(g & ((1 << DATA_W) - 1), act_mode, act_thr, s, e));
        end
        #2;
        last_ov = out_valid_o;
        @(posedge clk);
    endtask

    task automatic send(input int g, input bit s, input bit e, input int m, input int t);
        bit acc;
        acc = 0;
        for (int n = 0; n < 50 && !acc; n++) cycle(1, g, s, e, m, t, 1, acc);
        chk(acc, "send_accept", int'(acc), 1);
    endtask

    task automatic drain();
        bit acc;
        for (int n = 0; n < 100 && q.size() != 0; n++)
            cycle(0, 0, 0, 0, 0, 0, ($urandom % 4) != 0, acc);
        chk(q.size() == 0, "drain", q.size(), 0);
    endtask

    // Monitor: pops one expected beat per output transfer, checks stability under stall
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (prev_stall) begin
                chk(out_valid_o && int'(red_o) == held.r && int'(green_o) == held.g &&
                    int'(blue_o) == held.b && sof_o == held.sof && eol_o == held.eol,
                    "stall_hold", int'(red_o), held.r);
            end
            prev_stall = 0;
            if (out_valid_o && !out_ready_i) begin
                prev_stall = 1;
                held.r = int'(red_o); held.g = int'(green_o); held.b = int'(blue_o);
                held.sof = sof_o; held.eol = eol_o;
            end
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    chk(0, "spurious_beat", int'(red_o), 0);
                end else begin
                    e = q.pop_front();
                    chk(int'(red_o) == e.r, "red", int'(red_o), e.r);
                    chk(int'(green_o) == e.g, "green", int'(green_o), e.g);
                    chk(int'(blue_o) == e.b, "blue", int'(blue_o), e.b);
                    chk(sof_o == e.sof && eol_o == e.eol, "sideband",
                        int'({sof_o, eol_o}), int'({e.sof, e.eol}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst = 1; in_valid_i = 0; gray_i = 0; sof_i = 0; eol_i = 0;
        mode_i = 0; thresh_i = 0; out_ready_i = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #2;
        chk(out_valid_o == 0, "rst_valid", int'(out_valid_o), 0);
        chk(red_o == 0 && green_o == 0 && blue_o == 0, "rst_rgb", int'(red_o), 0);
        chk(in_ready_o == 1, "rst_ready", int'(in_ready_o), 1);
        mon_en = 1;

        // Latency: accepted beat appears after two edges
        cycle(1, 8'h5A, 1, 0, 0, 0, 1, acc);
        cycle(0, 0, 0, 0, 0, 0, 1, acc);
        chk(last_ov == 0, "latency_1", int'(last_ov), 0);
        cycle(0, 0, 0, 0, 0, 0, 1, acc);
        chk(last_ov == 1, "latency_2", int'(last_ov), 1);

        // Replication to wider channels
        send(8'hFF, 0, 0, 0, 0);
        send(8'h80, 0, 1, 0, 0);

        // Threshold; mode change without sof ignored
        send(99, 1, 0, 1, 100);
        send(100, 0, 0, 0, 200);
        send(101, 0, 0, 3, 0);

        // Heatmap breakpoints and ramps
        send(0, 1, 0, 2, 0);
        send(100, 0, 0, 0, 0);
        send(200, 0, 0, 0, 0);
        send(63, 0, 0, 0, 0);
        send(255, 0, 1, 0, 0);

        // Invert
        send(8'h3C, 1, 0, 3, 0);
        send(0, 0, 0, 0, 0);
        drain();

        // Back-pressure with an ordered stream
        for (int i = 0; i < 10; i++) begin
            acc = 0;
            for (int n = 0; n < 50 && !acc; n++)
                cycle(1, i, i == 0, i == 9, 0, 0, $urandom_range(0, 1), acc);
            chk(acc, "bp_accept", int'(acc), 1);
        end
        drain();

        // Randomised traffic
        for (int n = 0; n < 400; n++)
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 8) == 0, $urandom, $urandom,
                  $urandom, ($urandom % 4) != 0, acc);
        drain();

        // Reset with a full, stalled pipeline after switching to INVERT
        send(8'h11, 1, 0, 3, 0);
        for (int n = 0; n < 10 && q.size() < 2; n++)
            cycle(1, $urandom, 0, 0, 0, 0, 0, acc);
        chk(q.size() == 2, "fill_two", q.size(), 2);
        cycle(0, 0, 0, 0, 0, 0, 0, acc);
        @(negedge clk);
        mon_en = 0;
        prev_stall = 0;
        rst = 1; in_valid_i = 0; out_ready_i = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #2;
        chk(out_valid_o == 0, "mid_rst_valid", int'(out_valid_o), 0);
        chk(red_o == 0 && green_o == 0 && blue_o == 0 && sof_o == 0 && eol_o == 0,
            "mid_rst_out", int'(red_o), 0);
        chk(in_ready_o == 1, "mid_rst_ready", int'(in_ready_o), 1);
        q.delete();
        act_mode = 0;
        act_thr  = 0;
        #1;
        mon_en = 1;
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 1, acc);
        chk(last_ov == 0, "no_stale", int'(last_ov), 0);
        send(8'h33, 0, 0, 3, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
